// File: rtl/fsm_pair_tx.sv
// Moore serial transmitter: shifts a parallel word out MSB-first, then a zero guard gap; reports adjacent-11 pair count.
// Optional even-parity bit after bit 0 when PAIR_TX_PARITY_EN is defined.
module fsm_pair_tx #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_cnt
);

`ifdef PAIR_TX_PARITY_EN
    localparam int FRAME_W = WIDTH + 1;
`else
    localparam int FRAME_W = WIDTH;
`endif
    localparam int MAX_CNT = (FRAME_W > GAP_CYCLES) ? FRAME_W : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t             state;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] shift_reg;
    logic [CW-1:0]      cnt;
    logic [CNT_W-1:0]   acc;
    logic               prev_bit;

`ifdef PAIR_TX_PARITY_EN
    assign frame = {in_data, ^in_data};
`else
    assign frame = in_data;
`endif

    // in_ready is held low for the whole time rst is asserted
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
            acc       <= '0;
            prev_bit  <= 1'b0;
            ser_out   <= 1'b0;
            done      <= 1'b0;
            pair_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_valid && in_ready) begin
                        // shift_reg keeps the not-yet-driven bits, next one at the MSB
                        shift_reg <= frame << 1;
                        ser_out   <= frame[FRAME_W-1];
                        prev_bit  <= frame[FRAME_W-1];
                        cnt       <= CW'(1);
                        acc       <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(FRAME_W)) begin
                        ser_out  <= 1'b0;
                        pair_cnt <= acc;
                        done     <= 1'b1;
                        cnt      <= CW'(1);
                        state    <= GAP;
                    end else begin
                        ser_out   <= shift_reg[FRAME_W-1];
                        prev_bit  <= shift_reg[FRAME_W-1];
                        shift_reg <= shift_reg << 1;
                        if (prev_bit && shift_reg[FRAME_W-1])
                            acc <= acc + 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    done <= 1'b0;
                    if (cnt == CW'(GAP_CYCLES))
                        state <= IDLE;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_pair_tx.sv
// Directed bench for fsm_pair_tx (WIDTH=8, GAP_CYCLES=2); follows PAIR_TX_PARITY_EN if defined.
module tb_fsm_pair_tx;
    logic       clk = 1'b1;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready, ser_out, busy, done;
    logic [3:0] pair_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

`ifdef PAIR_TX_PARITY_EN
    localparam int F       = 9;
    localparam int P_B6    = 2;
    localparam int P_FF    = 7;
    localparam int P_00    = 0;
    localparam int P_01    = 1;
    localparam int P_6D    = 3;
`else
    localparam int F       = 8;
    localparam int P_B6    = 2;
    localparam int P_FF    = 7;
    localparam int P_00    = 0;
    localparam int P_01    = 0;
    localparam int P_6D    = 2;
`endif

    fsm_pair_tx #(.WIDTH(8), .GAP_CYCLES(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .busy(busy), .done(done),
        .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One full word: handshake, frame bits, GAP, back to IDLE. noise scrambles inputs during SHIFT.
    task automatic send(input string tag, input logic [7:0] d, input logic par,
                        input int exp_pairs, input bit noise);
        in_data  = d;
        in_valid = 1'b1;
        chk1({tag, " ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
            end
            chk1($sformatf("%s bit%0d", tag, 7 - k), ser_out, d[7-k]);
            chk1($sformatf("%s rdy_low%0d", tag, k), in_ready, 1'b0);
            if (k < 7) step();
        end
`ifdef PAIR_TX_PARITY_EN
        step();
        chk1({tag, " parity"}, ser_out, par);
`else
        chk1({tag, " par_unused"}, par, par ^ 1'b0);
`endif
        in_valid = 1'b0;
        step();
        chk1({tag, " gap1_ser"}, ser_out, 1'b0);
        chk1({tag, " done"}, done, 1'b1);
        chkn({tag, " pair_cnt"}, int'(pair_cnt), exp_pairs);
        step();
        chk1({tag, " gap2_ser"}, ser_out, 1'b0);
        chk1({tag, " done_low"}, done, 1'b0);
        chk1({tag, " gap2_busy"}, busy, 1'b1);
        step();
        chk1({tag, " idle_busy"}, busy, 1'b0);
        chk1({tag, " idle_ready"}, in_ready, 1'b1);
        chkn({tag, " pair_hold"}, int'(pair_cnt), exp_pairs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int first_hs, second_hs, n;
        #1;
        chk1("rst in_ready", in_ready, 1'b0);
        chk1("rst ser_out", ser_out, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst done", done, 1'b0);
        chkn("rst pair_cnt", int'(pair_cnt), 0);
        #14 rst = 1'b0;
        #1;
        chk1("post_rst in_ready", in_ready, 1'b1);
        step();

        send("B6", 8'hB6, 1'b1, P_B6, 1'b0);
        send("FF", 8'hFF, 1'b0, P_FF, 1'b0);
        send("00", 8'h00, 1'b0, P_00, 1'b0);
        send("01", 8'h01, 1'b1, P_01, 1'b0);

        // back-to-back with in_valid held high
        in_data  = 8'hB6;
        in_valid = 1'b1;
        chk1("b2b ready", in_ready, 1'b1);
        step();
        first_hs = cyc;
        in_data  = 8'h6D;
        chk1("b2b first_bit", ser_out, 1'b1);
        n = 0;
        while (!in_ready && n < 40) begin
            chk1("b2b busy", busy, 1'b1);
            if (done) chkn("b2b pair1", int'(pair_cnt), P_B6);
            step();
            n++;
        end
        chk1("b2b ready_timeout", in_ready, 1'b1);
        step();
        second_hs = cyc;
        in_valid  = 1'b0;
        chkn("b2b spacing", second_hs - first_hs, F + 3);
        chk1("b2b second_first_bit", ser_out, 1'b0);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk1("b2b done_timeout", done, 1'b1);
        chkn("b2b pair2", int'(pair_cnt), P_6D);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk1("b2b idle", busy, 1'b0);

        send("B6noise", 8'hB6, 1'b1, P_B6, 1'b1);

        // asynchronous reset mid-SHIFT after three bits
        in_data  = 8'hB6;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk1("mid bit5", ser_out, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("arst ser_out", ser_out, 1'b0);
        chk1("arst busy", busy, 1'b0);
        chkn("arst pair_cnt", int'(pair_cnt), 0);
        chk1("arst in_ready", in_ready, 1'b0);
        step();
        chk1("arst no_done", done, 1'b0);
        #4 rst = 1'b0;
        #1;
        chk1("rel in_ready", in_ready, 1'b1);
        chk1("rel busy", busy, 1'b0);
        step();
        chk1("rel done", done, 1'b0);
        chk1("rel ser_out", ser_out, 1'b0);

        send("6D", 8'h6D, 1'b1, P_6D, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fsm_pair_tx.md
Name: fsm_pair_tx

Overview:
Moore-style serial transmitter that produces the one-bit stream consumed by the team's pair-detector FSM. Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clock on ser_out. Inserts a zero guard gap after each word so the downstream detector sees idle-low between words. Reports the number of "11" pairs the detector must flag for that word, giving benches a self-checking reference.

Parameters:
WIDTH, 8, data word width in bits (>=2).
GAP_CYCLES, 2, number of forced-zero cycles on ser_out after each word (>=1).
CNT_W, 4, width of pair_cnt; must hold WIDTH (WIDTH+1 with parity).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  transmitter can accept a word
ser_out  output  1  serial stream to the pair detector
busy  output  1  high in SHIFT or GAP
done  output  1  one-cycle pulse at end of word
pair_cnt  output  CNT_W  count of adjacent-11 pairs in the last transmitted frame

Behaviour:
- Reset (async, rst=1): state=IDLE, ser_out=0, in_ready=0 while rst high, busy=0, done=0, pair_cnt=0, shift register and counters cleared. Outputs return to these values immediately, including mid-word; the word in flight is dropped.
- States: IDLE, SHIFT, GAP. All outputs are registered or decoded from state only (Moore).
- IDLE: in_ready=1, ser_out=0. Handshake = in_valid & in_ready at a rising edge. On that edge: shift_reg<=in_data, ser_out<=in_data[WIDTH-1], bit counter<=1, pair accumulator<=0, prev_bit<=in_data[WIDTH-1], state->SHIFT.
- SHIFT: in_ready=0, busy=1. Each edge ser_out takes the next lower bit. Bit k (k=WIDTH-1 down to 0) is on ser_out for exactly one cycle. First bit appears the cycle after the handshake edge.
- Pair counting: overlapping. Each time the newly driven bit and the previous bit are both 1, the accumulator increments. 8'hFF gives WIDTH-1 pairs. The idle 0 before and after the frame never forms a pair.
- After the last frame bit's cycle, the edge moves to GAP: ser_out<=0, pair_cnt<=accumulator, done=1 for this first GAP cycle only.
- GAP: ser_out=0 for exactly GAP_CYCLES cycles, busy=1, in_ready=0, then IDLE.
- pair_cnt holds its value until the next done. It does not change on handshake.
- in_data and in_valid are ignored outside IDLE. No buffering; back-to-back words are spaced WIDTH+GAP_CYCLES+1 cycles apart (handshake to handshake) with in_valid held high.
- Deasserting rst lands in IDLE. in_ready rises in the first cycle after rst falls.

Optional Feature:
Macro PAIR_TX_PARITY_EN.
- Defined: one even-parity bit (XOR of in_data) is appended after bit 0. The frame is WIDTH+1 bits long and the parity bit takes part in pair counting. done and GAP shift one cycle later.
- Undefined: the frame is exactly WIDTH bits with no parity logic.

Test Plan:
- WIDTH=8, GAP_CYCLES=2. Reset at time 0 for 15 ns, then send 8'hB6 -> ser_out=1,0,1,1,0,1,1,0 on consecutive cycles after handshake, then 0,0. done is high 1 cycle. pair_cnt=2.
- Send 8'hFF -> 8 consecutive ones on ser_out, pair_cnt=7. Then send 8'h00 -> all zeros, pair_cnt=0.
- Hold in_valid=1 with 8'hB6 then 8'h6D -> second handshake occurs exactly 11 cycles after the first. in_ready is low throughout SHIFT and GAP. pair_cnt=2 then 2.
- Assert rst asynchronously mid-SHIFT after 3 bits -> ser_out, busy and pair_cnt go to 0 immediately. No done pulse. in_ready=1 in the first cycle after rst falls.
- With PAIR_TX_PARITY_EN defined, send 8'h01 -> ser_out 0,0,0,0,0,0,0,1 then parity 1, pair_cnt=1. Without the macro the same word gives pair_cnt=0.
- Toggle in_valid during SHIFT with different in_data -> no effect on ser_out or pair_cnt.
